// File: rtl/pkt_store_tx.sv
`default_nettype none
// ==========================================================================
// pkt_store_tx : multi-slot TX packet store with per-packet length and sum,
// streamed out oldest-first in OUT_WIDTH chunks. Option: PKT_STORE_CKSUM_EN.
// Revision: 1.0
// ==========================================================================
module pkt_store_tx #(
  parameter int IN_WIDTH    = 16,
  parameter int OUT_WIDTH   = 2,
  parameter int DEPTH_WORDS = 256,
  parameter int NUM_SLOTS   = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              axiiv,
  input  logic [IN_WIDTH-1:0]               axiid,
  input  logic                              axii_last,
  input  logic [$clog2(IN_WIDTH/8+1)-1:0]   axii_nbytes,
  output logic                              in_ready,
  output logic                              pkt_avail,
  output logic [15:0]                       head_length,
  output logic [15:0]                       head_sum,
  input  logic                              read_request,
  input  logic                              axio_ready,
  output logic                              axiov,
  output logic [OUT_WIDTH-1:0]              axiod,
  output logic                              axio_last,
  output logic [15:0]                       drop_count
);
  localparam int BPW = IN_WIDTH / 8;
  localparam int AW  = $clog2(DEPTH_WORDS);
  localparam int SW  = $clog2(NUM_SLOTS);
  localparam int CPW = IN_WIDTH / OUT_WIDTH;
  localparam int CIW = (CPW > 1) ? $clog2(CPW) : 1;
  localparam int OSH = $clog2(OUT_WIDTH);
  localparam logic [AW:0]    WCNT_FULL = (AW+1)'(DEPTH_WORDS);
  localparam logic [SW:0]    SLOTS_CNT = (SW+1)'(NUM_SLOTS);
  localparam logic [CIW-1:0] CIDX_END  = CIW'(CPW - 1);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DISCARD} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM} rstate_t;

  wstate_t wstate, wstate_nx;
  rstate_t rstate, rstate_nx;

  logic [IN_WIDTH-1:0] mem [NUM_SLOTS*DEPTH_WORDS];
  logic [IN_WIDTH-1:0] rdata, sreg;
  logic [SW-1:0]       wr_ptr, rd_ptr, commit_slot;
  logic [SW:0]         count, occ;
  logic [AW:0]         wcnt;
  logic [AW-1:0]       rd_word;
  logic [CIW-1:0]      chunk_idx;
  logic [SW+AW-1:0]    waddr, raddr;
  logic [15:0]         len_acc, len_base, beat_nb, new_len, commit_len;
  logic [15:0]         slot_len [NUM_SLOTS];
  logic [18:0]         chunks_left, total_chunks;
  logic                commit_pend, free_slot, we, commit_set, drop_inc;
  logic                rd_en, rd_start, rd_load, free_set, xfer, word_end;

  // A pending commit already owns its slot, so it counts as occupied.
  assign occ         = count + {{SW{1'b0}}, commit_pend};
  assign free_slot   = occ < SLOTS_CNT;
  assign in_ready    = free_slot;
  assign pkt_avail   = count != '0;
  assign head_length = pkt_avail ? slot_len[rd_ptr] : 16'd0;

  assign len_base = (wstate == W_IDLE) ? 16'd0 : len_acc;
  assign beat_nb  = axii_last ? 16'(axii_nbytes) : 16'(BPW);
  assign new_len  = len_base + beat_nb;
  assign waddr    = {wr_ptr, (wstate == W_IDLE) ? {AW{1'b0}} : wcnt[AW-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate <= W_IDLE;
      rstate <= R_IDLE;
    end else begin
      wstate <= wstate_nx;
      rstate <= rstate_nx;
    end
  end

  always_comb begin
    wstate_nx  = wstate;
    we         = 1'b0;
    commit_set = 1'b0;
    drop_inc   = 1'b0;
    case (wstate)
      W_IDLE: if (axiiv) begin
        if (free_slot) begin
          we = 1'b1;
          if (axii_last) commit_set = 1'b1;
          else           wstate_nx  = W_FILL;
        end else if (axii_last) begin
          drop_inc = 1'b1;
        end else begin
          wstate_nx = W_DISCARD;
        end
      end
      W_FILL: if (axiiv) begin
        if (wcnt == WCNT_FULL) begin
          if (axii_last) begin
            drop_inc  = 1'b1;
            wstate_nx = W_IDLE;
          end else begin
            wstate_nx = W_DISCARD;
          end
        end else begin
          we = 1'b1;
          if (axii_last) begin
            commit_set = 1'b1;
            wstate_nx  = W_IDLE;
          end
        end
      end
      W_DISCARD: if (axiiv && axii_last) begin
        drop_inc  = 1'b1;
        wstate_nx = W_IDLE;
      end
      default: wstate_nx = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      wcnt        <= '0;
      len_acc     <= '0;
      commit_pend <= 1'b0;
      commit_slot <= '0;
      commit_len  <= '0;
      drop_count  <= '0;
    end else begin
      if (we) begin
        len_acc <= new_len;
        wcnt    <= (wstate == W_IDLE) ? (AW+1)'(1) : wcnt + 1'b1;
      end
      commit_pend <= commit_set;
      if (commit_set) begin
        commit_slot <= wr_ptr;
        commit_len  <= new_len;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (drop_inc && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) slot_len[i] <= '0;
    end else begin
      if (commit_pend) slot_len[commit_slot] <= commit_len;
      if (free_set) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{SW{1'b0}}, commit_pend} - {{SW{1'b0}}, free_set};
    end
  end

`ifdef PKT_STORE_CKSUM_EN
  logic [15:0] sum_acc, commit_sum, new_sum;
  logic [15:0] slot_sum [NUM_SLOTS];
  logic [19:0] beat_raw;
  logic [16:0] fold1;
  logic [7:0]  bt;

  // Byte parity comes from the running stream offset, not the lane index.
  always_comb begin
    bt       = 8'd0;
    beat_raw = {4'd0, (wstate == W_IDLE) ? 16'd0 : sum_acc};
    for (int j = 0; j < BPW; j++) begin
      bt = (16'(j) < beat_nb) ? axiid[IN_WIDTH-1-8*j -: 8] : 8'd0;
      if (len_base[0] ^ j[0]) beat_raw = beat_raw + {12'd0, bt};
      else                    beat_raw = beat_raw + {4'd0, bt, 8'd0};
    end
    fold1   = {1'b0, beat_raw[15:0]} + {13'd0, beat_raw[19:16]};
    new_sum = fold1[15:0] + {15'd0, fold1[16]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_acc    <= '0;
      commit_sum <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) slot_sum[i] <= '0;
    end else begin
      if (we) sum_acc <= new_sum;
      if (commit_set) commit_sum <= new_sum;
      if (commit_pend) slot_sum[commit_slot] <= commit_sum;
    end
  end

  assign head_sum = pkt_avail ? slot_sum[rd_ptr] : 16'd0;
`else
  assign head_sum = 16'd0;
`endif

  assign total_chunks = {head_length, 3'b000} >> OSH;
  assign xfer         = axiov && axio_ready;
  assign word_end     = chunk_idx == CIDX_END;
  assign axio_last    = axiov && (chunks_left == 19'd1);
  assign axiod        = sreg[IN_WIDTH-1 -: OUT_WIDTH];
  assign raddr        = {rd_ptr, rd_start ? {AW{1'b0}} : rd_word};

  always_comb begin
    rstate_nx = rstate;
    rd_en     = 1'b0;
    rd_start  = 1'b0;
    rd_load   = 1'b0;
    free_set  = 1'b0;
    case (rstate)
      R_IDLE: if (read_request && pkt_avail) begin
        rstate_nx = R_FETCH;
        rd_en     = 1'b1;
        rd_start  = 1'b1;
      end
      R_FETCH: begin
        rstate_nx = R_STREAM;
        rd_en     = 1'b1;
        rd_load   = 1'b1;
      end
      R_STREAM: if (xfer) begin
        if (chunks_left == 19'd1) begin
          free_set  = 1'b1;
          rstate_nx = R_IDLE;
        end else if (word_end) begin
          rd_load = 1'b1;
          rd_en   = 1'b1;
        end
      end
      default: rstate_nx = R_IDLE;
    endcase
  end

  // rdata always holds the word after the one being shifted out.
  always_ff @(posedge clk) begin
    if (we)    mem[waddr] <= axiid;
    if (rd_en) rdata <= mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      axiov       <= 1'b0;
      sreg        <= '0;
      chunk_idx   <= '0;
      chunks_left <= '0;
      rd_word     <= '0;
    end else begin
      if (rd_start) begin
        rd_word     <= AW'(1);
        chunks_left <= total_chunks;
      end
      if (rd_load) begin
        sreg      <= rdata;
        chunk_idx <= '0;
        rd_word   <= rd_word + 1'b1;
        axiov     <= 1'b1;
      end else if (xfer) begin
        sreg      <= sreg << OUT_WIDTH;
        chunk_idx <= chunk_idx + 1'b1;
      end
      if (xfer) chunks_left <= chunks_left - 19'd1;
      if (free_set) axiov <= 1'b0;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_pkt_store_tx.sv
`default_nettype none
// tb_pkt_store_tx : randomized bench for pkt_store_tx against a packet-queue
// reference model (IN=16, OUT=2, DEPTH_WORDS=4, NUM_SLOTS=2).
module tb_pkt_store_tx;
  localparam int IN_WIDTH = 16, OUT_WIDTH = 2, DEPTH_WORDS = 4, NUM_SLOTS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        axiiv;
  logic [15:0] axiid;
  logic        axii_last;
  logic [1:0]  axii_nbytes;
  logic        in_ready, pkt_avail;
  logic [15:0] head_length, head_sum;
  logic        read_request, axio_ready;
  logic        axiov;
  logic [1:0]  axiod;
  logic        axio_last;
  logic [15:0] drop_count;

  pkt_store_tx #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH),
                 .DEPTH_WORDS(DEPTH_WORDS), .NUM_SLOTS(NUM_SLOTS)) dut (
    .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid), .axii_last(axii_last),
    .axii_nbytes(axii_nbytes), .in_ready(in_ready), .pkt_avail(pkt_avail),
    .head_length(head_length), .head_sum(head_sum), .read_request(read_request),
    .axio_ready(axio_ready), .axiov(axiov), .axiod(axiod), .axio_last(axio_last),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: committed packets as a flat byte queue plus lengths.
  logic [7:0] store_bytes[$];
  int         store_len[$];
  int         drops;
  logic [7:0] tx_buf [0:15];
  int         tx_len;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_sum();
    int s;
    s = 0;
`ifdef PKT_STORE_CKSUM_EN
    for (int i = 0; i < store_len[0]; i++)
      s += (i % 2 == 0) ? (int'(store_bytes[i]) << 8) : int'(store_bytes[i]);
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
`endif
    return 16'(s);
  endfunction

  task automatic rand_pkt(input int len);
    tx_len = len;
    for (int i = 0; i < 16; i++) tx_buf[i] = 8'($urandom);
  endtask

  task automatic send_pkt();
    int beats;
    beats = (tx_len + 1) / 2;
    if (store_len.size() < NUM_SLOTS && beats <= DEPTH_WORDS) begin
      for (int i = 0; i < tx_len; i++) store_bytes.push_back(tx_buf[i]);
      store_len.push_back(tx_len);
    end else if (drops < 65535) begin
      drops++;
    end
    for (int b = 0; b < beats; b++) begin
      axiiv       = 1'b1;
      axiid[15:8] = tx_buf[2*b];
      axiid[7:0]  = (2*b + 1 < tx_len) ? tx_buf[2*b+1] : 8'($urandom);
      axii_last   = (b == beats - 1);
      axii_nbytes = axii_last ? 2'(tx_len - 2*b) : 2'($urandom);
      @(negedge clk);
    end
    axiiv     = 1'b0;
    axii_last = 1'b0;
    axiid     = 16'($urandom);
  endtask

  task automatic check_status();
    check("pkt_avail", pkt_avail, store_len.size() > 0);
    check("in_ready", in_ready, store_len.size() < NUM_SLOTS);
    check("drop_count", drop_count, drops);
    if (store_len.size() > 0) begin
      check("head_length", head_length, store_len[0]);
      check("head_sum", head_sum, exp_sum());
    end
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic read_pkt(input int mode);
    logic [2:0] exp_q[$];
    logic [7:0] tmp;
    logic [1:0] hd;
    logic       hl, held, done, rdy;
    int         len, n, cyc;
    len = store_len[0];
    for (int i = 0; i < len; i++) begin
      tmp = store_bytes[i];
      for (int k = 0; k < 4; k++)
        exp_q.push_back({(i == len - 1 && k == 3), 2'(tmp >> (6 - 2*k))});
    end
    read_request = 1'b1;
    @(negedge clk);
    read_request = 1'b0;
    check("axiov_lat1", axiov, 0);
    @(negedge clk);
    check("axiov_lat2", axiov, 1);
    n = 0; cyc = 0; held = 1'b0; done = 1'b0; hd = '0; hl = 1'b0;
    while (!done && cyc < 500) begin
      check("axiov_stream", axiov, 1);
      if (held) begin
        check("hold_d", axiod, hd);
        check("hold_last", axio_last, hl);
      end
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
      else                rdy = 1'($urandom_range(0, 1));
      axio_ready = rdy;
      if (axiov && rdy) begin
        if (n < exp_q.size()) check("chunk", {axio_last, axiod}, exp_q[n]);
        else                  check("chunk_overrun", n, exp_q.size() - 1);
        n++;
        held = 1'b0;
        if (axio_last) done = 1'b1;
      end else begin
        held = 1'b1; hd = axiod; hl = axio_last;
      end
      @(negedge clk);
      cyc++;
    end
    axio_ready = 1'b0;
    check("nchunks", n, exp_q.size());
    check("axiov_end", axiov, 0);
    for (int i = 0; i < len; i++) void'(store_bytes.pop_front());
    void'(store_len.pop_front());
  endtask

  initial begin
    rst = 1'b1; axiiv = 1'b0; axiid = '0; axii_last = 1'b0; axii_nbytes = '0;
    read_request = 1'b0; axio_ready = 1'b0; drops = 0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_pkt_avail", pkt_avail, 0);
    check("rst_head_length", head_length, 0);
    check("rst_head_sum", head_sum, 0);
    check("rst_axiov", axiov, 0);
    check("rst_axiod", axiod, 0);
    check("rst_axio_last", axio_last, 0);
    check("rst_drop_count", drop_count, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic three-beat packet, read with stalls
    tx_len = 6;
    tx_buf[0] = 8'h45; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
    tx_buf[3] = 8'h14; tx_buf[4] = 8'hAB; tx_buf[5] = 8'hCD;
    send_pkt();
    repeat (2) @(negedge clk);
    check("t1_length", head_length, 16'd6);
`ifdef PKT_STORE_CKSUM_EN
    check("t1_sum", head_sum, 16'hF0E1);
`endif
    check_status();
    read_pkt(1);
    check_status();

    // Odd length
    tx_len = 3; tx_buf[0] = 8'h12; tx_buf[1] = 8'h34; tx_buf[2] = 8'h56;
    send_pkt();
    repeat (2) @(negedge clk);
    check("t2_length", head_length, 16'd3);
`ifdef PKT_STORE_CKSUM_EN
    check("t2_sum", head_sum, 16'h6834);
`endif
    check_status();
    read_pkt(0);

    // Carry fold
    tx_len = 4; tx_buf[0] = 8'hFF; tx_buf[1] = 8'hFF; tx_buf[2] = 8'h00; tx_buf[3] = 8'h01;
    send_pkt();
    repeat (2) @(negedge clk);
`ifdef PKT_STORE_CKSUM_EN
    check("t3_sum", head_sum, 16'h0001);
`endif
    check_status();
    read_pkt(2);

    // Slots full: three back-to-back packets, third dropped
    for (int p = 0; p < 3; p++) begin
      rand_pkt($urandom_range(1, 4));
      send_pkt();
    end
    repeat (2) @(negedge clk);
    check("full_in_ready", in_ready, 0);
    check("full_drop", drop_count, 16'd1);
    check_status();
    read_pkt(2);
    check_status();
    read_pkt(2);
    check_status();

    // Oversize then a normal packet
    rand_pkt(10);
    send_pkt();
    repeat (2) @(negedge clk);
    check("ovf_pkt_avail", pkt_avail, 0);
    check("ovf_drop", drop_count, 16'd2);
    rand_pkt(4);
    send_pkt();
    repeat (2) @(negedge clk);
    check_status();
    read_pkt(0);

    // Random traffic
    for (int it = 0; it < 40; it++) begin
      int r;
      r = $urandom_range(0, 3);
      if (r == 0 && store_len.size() > 0) begin
        read_pkt(2);
      end else if (r == 1) begin
        for (int p = 0; p < int'($urandom_range(2, 3)); p++) begin
          rand_pkt($urandom_range(1, 9));
          send_pkt();
        end
      end else begin
        rand_pkt($urandom_range(1, 9));
        send_pkt();
      end
      repeat (2) @(negedge clk);
      check_status();
    end
    while (store_len.size() > 0) begin
      read_pkt(2);
      check_status();
    end

    // read_request with nothing stored is ignored
    read_request = 1'b1;
    @(negedge clk);
    read_request = 1'b0;
    repeat (2) @(negedge clk);
    check("rr_ignored", axiov, 0);

    // Reset in the middle of a stream
    rand_pkt(8); send_pkt();
    rand_pkt(5); send_pkt();
    repeat (2) @(negedge clk);
    check_status();
    read_request = 1'b1;
    axio_ready   = 1'b1;
    @(negedge clk);
    read_request = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_rst_axiov", axiov, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_axiov", axiov, 0);
    check("mrst_pkt_avail", pkt_avail, 0);
    check("mrst_drop", drop_count, 0);
    check("mrst_in_ready", in_ready, 1);
    rst = 1'b0;
    axio_ready = 1'b0;
    store_bytes.delete();
    store_len.delete();
    drops = 0;
    @(negedge clk);
    rand_pkt(7);
    send_pkt();
    repeat (2) @(negedge clk);
    check_status();
    read_pkt(1);
    check_status();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
